sevenseg_mux_driver: RTL and testbench
======================================

// Module: sevenseg_mux_driver
// PURPOSE
//  Time-multiplexed driver for an NDIGITS common-anode 7-segment display.
//  Holds a hex word, decodes one digit at a time, and scans the digit anodes
//  at a programmable refresh rate. Adds leading-zero blanking, per-digit
//  enables, decimal points and a ghosting guard band.
//  Display updates are frame-synchronised, so a digit never shows a mix of
//  old and new data. Sits between the CPU output port register and the
//  board display pins.
// PARAMETERS
//  NDIGITS     4      number of digits scanned (1..8)
//  REFRESH_DIV 50000  clock cycles per digit slot (>= GUARD+1, >= 2)
//  GUARD       500    cycles at the start of each slot with all anodes off (>= 0)
//  SEG_ACT_LOW 1      1: segments/dp active low; 0: active high
//  AN_ACT_LOW  1      1: anodes active low; 0: active high
// PORTS
//  clock       in   1            system clock, rising edge
//  reset       in   1            synchronous, active-high reset
//  value       in   4*NDIGITS    hex word; digit i = value[4*i+3:4*i], digit 0 = rightmost
//  dp_in       in   NDIGITS      decimal point per digit, 1 = lit
//  digit_en    in   NDIGITS      1 = digit may be lit; 0 = anode forced off
//  load        in   1            1-cycle strobe: capture value/dp_in into the pending register
//  blank_lz    in   1            1 = blank leading zero digits (sampled live)
//  segments    out  7            segment drive {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  dp          out  1            decimal point drive, polarity per SEG_ACT_LOW
//  anodes      out  NDIGITS      digit select, one-hot or none active, polarity per AN_ACT_LOW
//  frame_done  out  1            1-cycle pulse when the last digit slot of a frame ends
// BEHAVIOUR
//  Reset:
//   - slot_cnt=0, digit_idx=0; shown and pending registers = 0; pending_valid=0.
//   - All outputs registered; from the cycle after reset: segments/dp off, all anodes off, frame_done=0.
//  Scan:
//   - slot_cnt counts 0..REFRESH_DIV-1 and wraps.
//   - On wrap, digit_idx advances 0..NDIGITS-1, then back to 0.
//   - Frame length = NDIGITS*REFRESH_DIV cycles.
//  Frame boundary (slot_cnt==REFRESH_DIV-1 && digit_idx==NDIGITS-1):
//   - frame_done=1 on the next cycle.
//   - If pending_valid: shown<=pending, pending_valid<=0.
//  Load:
//   - pending<=value/dp_in, pending_valid<=1.
//   - A later load before the boundary overwrites pending.
//   - Load on the boundary cycle: shown takes the old pending; the new data goes
//     to pending and pending_valid stays 1.
//  Digit lit iff all of:
//   - slot_cnt>=GUARD;
//   - digit_en[digit_idx]=1;
//   - not LZ-blanked.
//  LZ-blanked: blank_lz=1, digit_idx>0, and shown nibbles digit_idx..NDIGITS-1 all zero.
//   - Digit 0 is never LZ-blanked.
//  Lit digit: anodes has only bit digit_idx active; segments = decode(nibble); dp = shown dp bit.
//  Unlit digit: all anodes inactive; segments and dp driven off.
//  Latency: outputs reflect the slot_cnt/digit_idx/shown state of the previous cycle (1 register stage).
//  Decode, active-high abcdefg order msb=g:
//   - 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F
//   - A-F: 77 7C 39 5E 79 71
//   - Active-low output = bitwise inverse.
//  Reset asserted mid-frame: counters, shown, pending and outputs return to reset values on the next edge.
//   - Any load in flight is discarded.
// STRUCTURE
//  Package sevenseg_pkg:
//   - typedef logic [3:0] nibble_t; typedef logic [6:0] seg_t;
//   - SEG_OFF constant; 16-entry active-high glyph table.
//  Sub-module sevenseg_hex_decode: combinational nibble_t -> seg_t (active high).
//   - Polarity inversion is done in sevenseg_mux_driver.
//  Top contains: slot counter, digit index, pending/shown registers, LZ-blank logic, output registers.
// TESTING (NDIGITS=4, REFRESH_DIV=4, GUARD=1, active-low both)
//  1 reset held 3 cycles -> anodes=4'b1111, segments=7'h7F, dp=1, frame_done=0; after release
//    frame_done pulses every 16 cycles.
//  2 load value=16'h12AF, dp_in=4'b0000; wait one frame boundary -> in the digit 0 slot:
//    guard cycle anodes=4'b1111, then 3 cycles anodes=4'b1110, segments=7'b0001110 (F);
//    digit 3 shows 7'b1111001 (1).
//  3 value=16'h0005, blank_lz=1 -> digits 3..1 anodes never active; digit 0 segments=7'b0010010;
//    with blank_lz=0, digit 3 shows 7'b1000000.
//  4 digit_en=4'b1011, dp_in=4'b0100 after load 16'h8888 -> digit 2 never active;
//    other digits show 7'b0000000 with dp=1 (dp_in bit is 0 for them).
//  5 load 16'h1111 mid-frame, then 16'h2222 on the boundary cycle -> next frame shows all 1;
//    the frame after shows all 2; no frame mixes digits.
//  6 reset asserted in the digit 2 slot -> next cycle all anodes off; after release, scan restarts
//    at digit 0 showing 0, and the pending load is lost.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and glyph table for the
// multiplexed seven-segment display driver.
package sevenseg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // active-high {g,f,e,d,c,b,a}
  localparam seg_t GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_mux_driver_if.sv
// Display port bundle: CPU-side data/strobes
// toward the driver, pin drive back out.
interface sevenseg_mux_driver_if
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS = 4
);

  logic [4*NDIGITS-1:0] value;
  logic [NDIGITS-1:0]   dp_in;
  logic [NDIGITS-1:0]   digit_en;
  logic                 load;
  logic                 blank_lz;
  seg_t                 segments;
  logic                 dp;
  logic [NDIGITS-1:0]   anodes;
  logic                 frame_done;

  modport master (
    output value, dp_in, digit_en,
    output load, blank_lz,
    input  segments, dp, anodes,
    input  frame_done
  );

  modport slave (
    input  value, dp_in, digit_en,
    input  load, blank_lz,
    output segments, dp, anodes,
    output frame_done
  );

endinterface

// File: rtl/sevenseg_hex_decode.sv
// Hex nibble to active-high segment pattern.
// Polarity is applied by the caller.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  nibble_t nib,
  output seg_t    seg
);

  assign seg = GLYPH[nib];

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Scanned seven-segment driver with frame-synced
// updates, leading-zero blanking and guard band.
module sevenseg_mux_driver
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input logic clock,
  input logic reset,
  sevenseg_mux_driver_if.slave disp
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW =
    (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST =
    SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] GUARD_END =
    SW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NDIGITS - 1);

  localparam bit SEG_INV = SEG_ACT_LOW != 0;
  localparam bit AN_INV  = AN_ACT_LOW != 0;

  localparam seg_t SEG_IDLE =
    SEG_OFF ^ {7{SEG_INV}};
  localparam logic [NDIGITS-1:0] AN_IDLE =
    {NDIGITS{AN_INV}};

  logic [SW-1:0]        slot_cnt;
  logic [IW-1:0]        digit_idx;
  logic [4*NDIGITS-1:0] shown_val;
  logic [4*NDIGITS-1:0] pend_val;
  logic [NDIGITS-1:0]   shown_dp;
  logic [NDIGITS-1:0]   pend_dp;
  logic                 pend_valid;

  logic               slot_end;
  logic               frame_end;
  logic [NDIGITS-1:0] zero_above;
  logic               zero_acc;
  logic               lz_blank;
  logic               lit;
  logic [NDIGITS-1:0] an_sel;
  nibble_t            nib;
  seg_t               glyph;

  assign slot_end  = slot_cnt == SLOT_LAST;
  assign frame_end = slot_end &&
                     digit_idx == IDX_LAST;

  // zero_above[i]: nibbles i..top are all zero
  always_comb begin
    zero_above = '0;
    zero_acc   = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc &&
                      shown_val[4*i +: 4] == 4'h0;
      zero_above[i] = zero_acc;
    end
  end

  assign lz_blank = disp.blank_lz &&
                    digit_idx != '0 &&
                    zero_above[digit_idx];

  assign lit = slot_cnt >= GUARD_END &&
               disp.digit_en[digit_idx] &&
               !lz_blank;

  assign nib    = shown_val[4*int'(digit_idx) +: 4];
  assign an_sel = NDIGITS'(1) << digit_idx;

  sevenseg_hex_decode u_dec (
    .nib (nib),
    .seg (glyph)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt        <= '0;
      digit_idx       <= '0;
      shown_val       <= '0;
      shown_dp        <= '0;
      pend_val        <= '0;
      pend_dp         <= '0;
      pend_valid      <= 1'b0;
      disp.segments   <= SEG_IDLE;
      disp.dp         <= SEG_INV;
      disp.anodes     <= AN_IDLE;
      disp.frame_done <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        digit_idx <= (digit_idx == IDX_LAST) ?
                     '0 : digit_idx + 1'b1;

      if (frame_end && pend_valid) begin
        shown_val  <= pend_val;
        shown_dp   <= pend_dp;
        pend_valid <= 1'b0;
      end
      // a load on the boundary refills pending
      if (disp.load) begin
        pend_val   <= disp.value;
        pend_dp    <= disp.dp_in;
        pend_valid <= 1'b1;
      end

      disp.frame_done <= frame_end;
      if (lit) begin
        disp.anodes   <= an_sel ^ AN_IDLE;
        disp.segments <= glyph ^ {7{SEG_INV}};
        disp.dp       <= shown_dp[digit_idx] ^ SEG_INV;
      end else begin
        disp.anodes   <= AN_IDLE;
        disp.segments <= SEG_IDLE;
        disp.dp       <= SEG_INV;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Random and directed bench for the display driver
// against a cycle-count reference model.
module tb_sevenseg_mux_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int FL = N * RD;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sevenseg_mux_driver_if #(.NDIGITS(N)) disp ();

  sevenseg_mux_driver #(
    .NDIGITS     (N),
    .REFRESH_DIV (RD),
    .GUARD       (G),
    .SEG_ACT_LOW (1),
    .AN_ACT_LOW  (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .disp  (disp.slave)
  );

  always #5 clock = ~clock;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_chk  = 0;
  int n_pass = 0;

  int          t;
  bit          armed = 0;
  logic [15:0] shown, pend;
  logic [3:0]  shown_dp, pend_dp;
  bit          pv;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s t=%0d got %h want %h",
               tag, t, got, exp);
    else
      n_pass++;
  endtask

  // model: position in the scan is pure arithmetic
  // on the number of cycles since reset release
  task automatic tick();
    int         slot, idx;
    bit         lit, lz;
    logic [3:0] nib;
    @(posedge clock);
    if (reset) begin
      armed = 1;
      t = 0; shown = '0; pend = '0;
      shown_dp = '0; pend_dp = '0; pv = 0;
      e_an = 4'hF; e_seg = 7'h7F;
      e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      slot = t % RD;
      idx  = (t / RD) % N;
      nib  = 4'(shown >> (4 * idx));
      lz   = disp.blank_lz && idx > 0 &&
             (shown >> (4 * idx)) == 0;
      lit  = slot >= G &&
             disp.digit_en[idx] && !lz;
      if (lit) begin
        e_an  = ~(4'b0001 << idx);
        e_seg = ~glyph[nib];
        e_dp  = ~shown_dp[idx];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      e_fd = (t % FL) == FL - 1;
      if (e_fd && pv) begin
        shown = pend; shown_dp = pend_dp; pv = 0;
      end
      if (disp.load) begin
        pend = disp.value; pend_dp = disp.dp_in;
        pv = 1;
      end
      t++;
    end
    #1;
    if (armed) begin
      chk("anodes", 32'(disp.anodes), 32'(e_an));
      chk("segments", 32'(disp.segments),
          32'(e_seg));
      chk("dp", 32'(disp.dp), 32'(e_dp));
      chk("frame_done", 32'(disp.frame_done),
          32'(e_fd));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(
    input logic [15:0] v,
    input logic [3:0]  d
  );
    disp.value = v; disp.dp_in = d;
    disp.load = 1'b1;
    tick();
    disp.load = 1'b0;
  endtask

  task automatic to_boundary();
    for (int i = 0; i < FL && t % FL != FL - 1; i++)
      tick();
  endtask

  initial begin
    logic [15:0] mask;
    disp.value = '0; disp.dp_in = '0;
    disp.digit_en = 4'hF; disp.load = 1'b0;
    disp.blank_lz = 1'b0;

    ticks(3);
    reset = 1'b0;
    ticks(2 * FL);

    do_load(16'h12AF, 4'b0000);
    ticks(2 * FL);

    disp.blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000);
    ticks(2 * FL);
    disp.blank_lz = 1'b0;
    ticks(FL);

    disp.digit_en = 4'b1011;
    do_load(16'h8888, 4'b0100);
    ticks(2 * FL);
    disp.digit_en = 4'hF;

    ticks(5);
    do_load(16'h1111, 4'b0001);
    to_boundary();
    do_load(16'h2222, 4'b1000);
    ticks(3 * FL);

    for (int i = 0; i < FL && (t / RD) % N != 2; i++)
      tick();
    do_load(16'hABCD, 4'b1111);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(2 * FL);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 16'hFFFF;
          1:       mask = 16'h00FF;
          2:       mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        disp.value = 16'($urandom) & mask;
        disp.dp_in = 4'($urandom);
        disp.load = 1'b1;
      end else begin
        disp.load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0)
        disp.blank_lz = ~disp.blank_lz;
      if ($urandom_range(0, 199) == 0)
        disp.digit_en = 4'($urandom);
      reset = $urandom_range(0, 699) == 0;
      tick();
    end
    reset = 1'b0;
    disp.load = 1'b0;
    ticks(FL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
